// File: rtl/dawg_partitioned_set_if.sv
// Lookup, configuration and flush bundle for dawg_partitioned_set.
// slave: the set. master: the OS/user side driving requests.
interface dawg_partitioned_set_if #(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_DOMAINS = 4
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int DOM_W = $clog2(NUM_DOMAINS);

  logic                  cfg_valid;
  logic [DOM_W-1:0]      cfg_domain;
  logic [NUM_WAYS-1:0]   cfg_waymask;
  logic                  flush_req;
  logic [DOM_W-1:0]      flush_domain;
  logic                  req_valid;
  logic                  req_ready;
  logic [DOM_W-1:0]      req_domain;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [WAY_W-1:0]      resp_way;
  logic                  resp_fill;
  logic                  busy;
  logic                  flush_done;

  modport slave (
    input  cfg_valid, cfg_domain, cfg_waymask,
    input  flush_req, flush_domain,
    input  req_valid, req_domain, req_addr,
    output req_ready,
    output resp_valid, resp_hit, resp_way, resp_fill,
    output busy, flush_done
  );

  modport master (
    output cfg_valid, cfg_domain, cfg_waymask,
    output flush_req, flush_domain,
    output req_valid, req_domain, req_addr,
    input  req_ready,
    input  resp_valid, resp_hit, resp_way, resp_fill,
    input  busy, flush_done
  );
endinterface

// File: rtl/dawg_partitioned_set.sv
// One way-partitioned cache set: per-domain way masks, NRU fill, domain flush.
// Ports: clk, reset (async low), bus (slave), stat_* under DAWG_STATS_EN.
module dawg_partitioned_set #(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_DOMAINS = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef DAWG_STATS_EN
  input  logic [$clog2(NUM_DOMAINS)-1:0] stat_domain,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  dawg_partitioned_set_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e                state_q;
  logic [WAY_W-1:0]      cnt_q;
  logic [NUM_WAYS-1:0]   fmask_q;
  logic [NUM_WAYS-1:0]   valid_q;
  logic [NUM_WAYS-1:0]   nru_q;
  logic [ADDR_WIDTH-1:0] tag_q [NUM_WAYS];
  logic [NUM_WAYS-1:0]   mask_q [NUM_DOMAINS];
  logic                  resp_valid_q;
  logic                  resp_hit_q;
  logic                  resp_fill_q;
  logic [WAY_W-1:0]      resp_way_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  accept;
  logic [NUM_WAYS-1:0]   dmask;
  logic [NUM_WAYS-1:0]   hitv;
  logic [NUM_WAYS-1:0]   invv;
  logic [NUM_WAYS-1:0]   nruv;
  logic [NUM_WAYS-1:0]   accv;
  logic [NUM_WAYS-1:0]   nru_d;
  logic                  hit;
  logic [WAY_W-1:0]      vic_way;
  logic [WAY_W-1:0]      acc_way;

  function automatic logic [WAY_W-1:0] lowest(
    input logic [NUM_WAYS-1:0] v
  );
    lowest = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--)
      if (v[i]) lowest = WAY_W'(i);
  endfunction

  always_comb begin
    dmask = mask_q[bus.req_domain];
    hitv  = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      hitv[i] = dmask[i] & valid_q[i]
              & (tag_q[i] == bus.req_addr);
    invv = dmask & ~valid_q;
    nruv = dmask & ~nru_q;
    hit  = |hitv;
    if (|invv)      vic_way = lowest(invv);
    else if (|nruv) vic_way = lowest(nruv);
    else            vic_way = lowest(dmask);
    acc_way = hit ? lowest(hitv) : vic_way;
    accv    = NUM_WAYS'(1) << acc_way;
    nru_d   = nru_q | accv;
    // NRU wrap: keep only the just-touched way inside the mask
    if ((nru_d & dmask) == dmask)
      nru_d = (nru_q & ~dmask) | accv;
  end

  assign bus.req_ready = (state_q == IDLE)
                       && !bus.flush_req
                       && !bus.cfg_valid;
  assign accept = bus.req_ready && bus.req_valid;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_fill  = resp_fill_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.busy       = busy_q;
  assign bus.flush_done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fmask_q      <= '0;
      valid_q      <= '0;
      nru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_fill_q  <= 1'b0;
      resp_way_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_WAYS; i++)
        tag_q[i] <= '0;
      for (int d = 0; d < NUM_DOMAINS; d++)
        mask_q[d] <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_fill_q  <= 1'b0;
      resp_way_q   <= '0;
      done_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.flush_req) begin
            fmask_q <= mask_q[bus.flush_domain];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FLUSH;
          end else if (bus.cfg_valid) begin
            mask_q[bus.cfg_domain] <= bus.cfg_waymask;
          end else if (bus.req_valid) begin
            resp_valid_q <= 1'b1;
            if (|dmask) begin
              resp_hit_q  <= hit;
              resp_fill_q <= !hit;
              resp_way_q  <= acc_way;
              nru_q       <= nru_d;
              if (!hit) begin
                tag_q[vic_way]   <= bus.req_addr;
                valid_q[vic_way] <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (fmask_q[cnt_q]) begin
            tag_q[cnt_q]   <= '0;
            valid_q[cnt_q] <= 1'b0;
            nru_q[cnt_q]   <= 1'b0;
          end
          cnt_q  <= cnt_q + WAY_W'(1);
          // done is registered, so raise it one visit early
          done_q <= (cnt_q == WAY_W'(NUM_WAYS-2));
          if (cnt_q == WAY_W'(NUM_WAYS-1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DAWG_STATS_EN
  logic [15:0] hits_q [NUM_DOMAINS];
  logic [15:0] miss_q [NUM_DOMAINS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        hits_q[d] <= '0;
        miss_q[d] <= '0;
      end
    end else if (state_q == IDLE && bus.flush_req) begin
      hits_q[bus.flush_domain] <= '0;
      miss_q[bus.flush_domain] <= '0;
    end else if (accept) begin
      if (|dmask && hit) begin
        if (hits_q[bus.req_domain] != 16'hFFFF)
          hits_q[bus.req_domain] <= hits_q[bus.req_domain] + 16'd1;
      end else begin
        if (miss_q[bus.req_domain] != 16'hFFFF)
          miss_q[bus.req_domain] <= miss_q[bus.req_domain] + 16'd1;
      end
    end
  end

  assign stat_hits   = hits_q[stat_domain];
  assign stat_misses = miss_q[stat_domain];
`endif
endmodule

// File: tb/tb_dawg_partitioned_set.sv
// Randomized bench for dawg_partitioned_set against a behavioural model.
// Optional stats checks follow DAWG_STATS_EN.
module tb_dawg_partitioned_set;
  localparam int NW = 8;
  localparam int AW = 16;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dawg_partitioned_set_if #(
    .NUM_WAYS(NW), .ADDR_WIDTH(AW), .NUM_DOMAINS(ND)
  ) bus ();

`ifdef DAWG_STATS_EN
  logic [1:0]  stat_domain = '0;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
`endif

  dawg_partitioned_set #(
    .NUM_WAYS(NW), .ADDR_WIDTH(AW), .NUM_DOMAINS(ND)
  ) dut (
    .clk(clk),
    .reset(rst_n),
`ifdef DAWG_STATS_EN
    .stat_domain(stat_domain),
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural model
  logic [AW-1:0] m_tag [NW];
  bit            m_val [NW];
  bit            m_nru [NW];
  logic [NW-1:0] m_mask [ND];
  int            m_hits [ND];
  int            m_miss [ND];

  bit r_hit;
  bit r_fill;
  int r_way;

  task automatic m_reset();
    for (int i = 0; i < NW; i++) begin
      m_tag[i] = '0; m_val[i] = 0; m_nru[i] = 0;
    end
    for (int d = 0; d < ND; d++) begin
      m_mask[d] = '0; m_hits[d] = 0; m_miss[d] = 0;
    end
  endtask

  task automatic m_lookup(input int d, input int a,
                          output bit eh, output int ew,
                          output bit ef);
    logic [NW-1:0] dm;
    bit all;
    dm = m_mask[d];
    eh = 0; ew = 0; ef = 0;
    if (dm == 0) begin
      if (m_miss[d] < 65535) m_miss[d]++;
      return;
    end
    for (int i = 0; i < NW; i++)
      if (!eh && dm[i] && m_val[i] && m_tag[i] == a[AW-1:0]) begin
        eh = 1; ew = i;
      end
    if (!eh) begin
      ew = -1;
      for (int i = 0; i < NW; i++)
        if (ew < 0 && dm[i] && !m_val[i]) ew = i;
      for (int i = 0; i < NW; i++)
        if (ew < 0 && dm[i] && !m_nru[i]) ew = i;
      for (int i = 0; i < NW; i++)
        if (ew < 0 && dm[i]) ew = i;
      ef = 1;
      m_tag[ew] = a[AW-1:0];
      m_val[ew] = 1;
    end
    m_nru[ew] = 1;
    all = 1;
    for (int i = 0; i < NW; i++)
      if (dm[i] && !m_nru[i]) all = 0;
    if (all)
      for (int i = 0; i < NW; i++)
        if (dm[i] && i != ew) m_nru[i] = 0;
    if (eh) begin
      if (m_hits[d] < 65535) m_hits[d]++;
    end else begin
      if (m_miss[d] < 65535) m_miss[d]++;
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_valid = 0; bus.cfg_domain = '0; bus.cfg_waymask = '0;
    bus.flush_req = 0; bus.flush_domain = '0;
    bus.req_valid = 0; bus.req_domain = '0; bus.req_addr = '0;
  endtask

  task automatic check_stats(input int d);
`ifdef DAWG_STATS_EN
    stat_domain = d[1:0];
    #1;
    check("stat_hits", stat_hits, m_hits[d]);
    check("stat_misses", stat_misses, m_miss[d]);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  task automatic do_req(input int d, input int a);
    bit eh, ef;
    int ew;
    @(negedge clk);
    bus.req_valid  = 1;
    bus.req_domain = d[1:0];
    bus.req_addr   = a[AW-1:0];
    #1;
    check("req_ready", bus.req_ready, 1);
    m_lookup(d, a, eh, ew, ef);
    @(negedge clk);
    bus.req_valid = 0;
    r_hit  = bus.resp_hit;
    r_fill = bus.resp_fill;
    r_way  = int'(bus.resp_way);
    check("resp_valid", bus.resp_valid, 1);
    check("resp_hit", bus.resp_hit, eh);
    check("resp_fill", bus.resp_fill, ef);
    check("resp_way", bus.resp_way, ew);
    check_stats(d);
  endtask

  task automatic do_cfg(input int d, input logic [NW-1:0] m);
    @(negedge clk);
    bus.cfg_valid   = 1;
    bus.cfg_domain  = d[1:0];
    bus.cfg_waymask = m;
    bus.req_valid   = 1'($urandom_range(0, 1));
    #1;
    check("cfg_ready", bus.req_ready, 0);
    m_mask[d] = m;
    @(negedge clk);
    bus.cfg_valid = 0;
    bus.req_valid = 0;
    check("cfg_resp", bus.resp_valid, 0);
  endtask

  task automatic do_flush(input int d, input bit all);
    logic [NW-1:0] fm;
    @(negedge clk);
    bus.flush_req    = 1;
    bus.flush_domain = d[1:0];
    if (all) begin
      bus.cfg_valid   = 1;
      bus.cfg_domain  = 2'($urandom_range(0, ND-1));
      bus.cfg_waymask = 8'($urandom);
      bus.req_valid   = 1;
    end
    #1;
    check("flush_ready", bus.req_ready, 0);
    fm = m_mask[d];
    m_hits[d] = 0;
    m_miss[d] = 0;
    @(negedge clk);
    bus.flush_req = 0;
    bus.cfg_valid = 0;
    bus.req_valid = 1;
    for (int i = 0; i < NW; i++) begin
      check("busy", bus.busy, 1);
      check("flush_done", bus.flush_done, (i == NW-1));
      check("fl_ready", bus.req_ready, 0);
      check("fl_resp", bus.resp_valid, 0);
      @(negedge clk);
    end
    bus.req_valid = 0;
    check("busy_end", bus.busy, 0);
    check("done_end", bus.flush_done, 0);
    check("resp_end", bus.resp_valid, 0);
    for (int i = 0; i < NW; i++)
      if (fm[i]) begin
        m_tag[i] = '0; m_val[i] = 0; m_nru[i] = 0;
      end
    check_stats(d);
  endtask

  initial begin
    int seen;
    int op;
    idle_inputs();
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.flush_done, 0);
    check("rst_resp", bus.resp_valid, 0);
    check("rst_hit", bus.resp_hit, 0);
    check("rst_way", bus.resp_way, 0);
    check("rst_fill", bus.resp_fill, 0);
    check("rst_ready", bus.req_ready, 1);
    rst_n = 1;

    // first fill, then hit; empty mask domain
    do_cfg(0, 8'h0F);
    do_req(0, 'h12);
    check("v21_hit", r_hit, 0);
    check("v21_fill", r_fill, 1);
    check("v21_way", r_way, 0);
    do_req(0, 'h12);
    check("v21_hit2", r_hit, 1);
    check("v21_way2", r_way, 0);
    do_req(3, 'h5);
    check("empty_fill", r_fill, 0);
    check("empty_way", r_way, 0);

    // isolation between domains
    do_cfg(1, 8'hF0);
    do_req(1, 'h12);
    check("v22_hit", r_hit, 0);
    check("v22_way", r_way, 4);
    do_req(0, 'h12);
    check("v22_d0hit", r_hit, 1);
    check("v22_d0way", r_way, 0);

    // flush domain 0
    do_flush(0, 0);
    do_req(0, 'h12);
    check("v24_miss", r_hit, 0);
    do_req(1, 'h12);
    check("v24_d1hit", r_hit, 1);
    check("v24_d1way", r_way, 4);

    // NRU victim choice and wrap
    do_reset();
    do_cfg(0, 8'h0F);
    for (int a = 'h10; a <= 'h13; a++) do_req(0, a);
    do_req(0, 'h12);
    check("v23_hit2", r_way, 2);
    do_req(0, 'h20);
    check("v23_evict0", r_way, 0);
    do_req(0, 'h21);
    check("v23_way1", r_way, 1);
    do_req(0, 'h12);
    do_req(0, 'h23);
    check("v23_way0", r_way, 0);
    do_req(0, 'h24);
    check("v23_way3", r_way, 3);

    // reset during a flush
    @(negedge clk);
    bus.flush_req = 1;
    bus.flush_domain = '0;
    @(negedge clk);
    bus.flush_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("v25_busy", bus.busy, 0);
    check("v25_done", bus.flush_done, 0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.flush_done || bus.busy) seen++;
    end
    check("v25_nodone", seen, 0);

    // flush wins over cfg and req
    do_cfg(0, 8'h0F);
    do_flush(0, 1);
    do_req(0, 'h40);
    check("v25_inmask", r_way, 0);

`ifdef DAWG_STATS_EN
    do_reset();
    do_cfg(2, 8'h01);
    do_req(2, 'h5);
    @(negedge clk);
    bus.req_valid  = 1;
    bus.req_domain = 2'd2;
    bus.req_addr   = 16'h5;
    repeat (70000) @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    m_hits[2] = 65535;
    stat_domain = 2'd2;
    #1;
    check("v26_sat", stat_hits, 16'hFFFF);
    check("v26_miss", stat_misses, 1);
`endif

    // random traffic
    do_reset();
    for (int d = 0; d < ND; d++) do_cfg(d, 8'($urandom));
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 99);
      if (op < 6)
        do_cfg($urandom_range(0, ND-1), 8'($urandom));
      else if (op < 9)
        do_flush($urandom_range(0, ND-1), 1'($urandom));
      else
        do_req($urandom_range(0, ND-1), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dawg_partitioned_set.md
DAWG_PARTITIONED_SET -- requirements
Module: dawg_partitioned_set

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8: ways in the set, a power of two from 2 to 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: tag width in bits.
REQ-003 SHALL have parameter NUM_DOMAINS, default 4: security domains, a power of two of at least 2; WAY_W = clog2(NUM_WAYS) and DOM_W = clog2(NUM_DOMAINS).
REQ-004 SHALL have ports:
  clk  in  1  sole clock; all state updates on its rising edge
  reset  in  1  asynchronous, active-low reset
  cfg_valid  in  1  OS writes a domain's way mask
  cfg_domain  in  DOM_W  domain being configured
  cfg_waymask  in  NUM_WAYS  ways owned by cfg_domain
  flush_req  in  1  OS flush of one domain
  flush_domain  in  DOM_W  domain to flush
  req_valid  in  1  user lookup request
  req_ready  out  1  lookup accepted when high together with req_valid
  req_domain  in  DOM_W  requesting domain
  req_addr  in  ADDR_WIDTH  lookup tag
  resp_valid  out  1  one-cycle response pulse
  resp_hit  out  1  hit flag
  resp_way  out  WAY_W  hit way or filled way
  resp_fill  out  1  miss caused a fill
  busy  out  1  flush in progress
  flush_done  out  1  one-cycle pulse on the last flush cycle
  stat_domain, stat_hits, stat_misses  in DOM_W, out 16, out 16  statistics read port (present only under DAWG_STATS_EN)

Function
REQ-005 SHALL be a two-state FSM, IDLE and FLUSH; priority in IDLE: flush_req, then cfg_valid, then req_valid.
REQ-006 SHALL drive req_ready = (state==IDLE) && !flush_req && !cfg_valid, combinationally.
REQ-007 SHALL, when cfg_valid in IDLE, load mask[cfg_domain] = cfg_waymask; tags, valid and metadata are untouched; overlapping masks are legal and are not checked.
REQ-008 SHALL, on an accepted lookup, treat ways with mask[req_domain]=1 and valid=1 and tag==req_addr as hits; the lowest-index match wins.
REQ-009 SHALL register resp_valid, resp_hit, resp_way and resp_fill in the cycle after acceptance, giving 1-cycle latency; resp_valid SHALL be low otherwise.
REQ-010 SHALL, on a miss, pick the victim as the lowest invalid in-mask way; if none, the lowest in-mask way with NRU bit 0; if none, the lowest in-mask way; write the tag, set valid, and set resp_fill=1 and resp_way=victim.
REQ-011 SHALL, on each hit or fill, set the accessed way's NRU bit; if all in-mask bits are then 1, clear every in-mask bit except the accessed way; bits outside the mask are never altered.
REQ-012 SHALL, for an empty mask, respond resp_hit=0, resp_fill=0, resp_way=0 and change no state.
REQ-013 SHALL, on flush_req in IDLE, latch mask[flush_domain] and enter FLUSH with busy=1 from the next cycle.
REQ-014 SHALL, in FLUSH, visit way index 0..NUM_WAYS-1 at one per cycle, clearing tag, valid and NRU bit of each latched-mask way.
REQ-015 SHALL pulse flush_done in the cycle that visits way NUM_WAYS-1, then return to IDLE; a flush lasts exactly NUM_WAYS cycles.
REQ-016 SHALL ignore flush_req and cfg_valid while in FLUSH; no request is accepted in FLUSH.

Reset
REQ-017 SHALL, while reset=0, asynchronously clear all tags, valid bits, NRU bits, masks, the way counter and the statistics, set state=IDLE, and hold resp_valid, resp_hit, resp_way, resp_fill, busy and flush_done at 0.
REQ-018 SHALL abandon a flush in progress on reset; no flush_done SHALL follow.

Configuration
REQ-019 SHALL, with DAWG_STATS_EN defined, keep per-domain 16-bit saturating hit and miss counters, incremented on accepted lookups (an empty-mask miss counts), cleared for a domain when its flush starts, and read combinationally via stat_domain.
REQ-020 SHALL, without DAWG_STATS_EN, omit the counters and the stat_* ports; all other behaviour is identical.

Verification
REQ-021 SHALL cover: cfg domain0 mask 0x0F, lookup addr 0x12 -> cycle+1: resp_hit=0, resp_fill=1, resp_way=0; repeat lookup -> resp_hit=1, resp_way=0.
REQ-022 SHALL cover: domain1 mask 0xF0 looks up 0x12 already held in way0 by domain0 -> miss, fill way4; domain0 way0 is intact.
REQ-023 SHALL cover: fill ways 0-3 of mask 0x0F, hit way2 -> next miss evicts way0; a full-NRU wrap clears all bits but the accessed way.
REQ-024 SHALL cover: flush_req domain0 with NUM_WAYS=8 -> busy for 8 cycles, flush_done on the 8th, req_ready=0 throughout; a later lookup of 0x12 misses.
REQ-025 SHALL cover: reset asserted mid-flush at cycle 3 -> busy=0 immediately, no flush_done; flush_req, cfg_valid and req_valid together -> flush wins.
REQ-026 SHALL cover: with DAWG_STATS_EN, 70000 hits -> stat_hits saturates at 0xFFFF.
